// File: rtl/operand_stage.sv
// Operand stage: builds RV32I operands from decode, holds them for execute,
// and inserts a single bubble when an instruction needs a load's result.
module operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            id_op1_sel,
  input  logic [2:0]      id_op2_sel,
  input  logic            id_invalid,
  input  logic            id_jump,
  input  logic            id_load,
  input  logic            kill,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_jump,
  output logic            ex_trap,
  output logic [31:0]     bubble_count
);

  localparam logic [2:0] SEL_RS2 = 3'd0;
  localparam logic [2:0] SEL_I   = 3'd1;
  localparam logic [2:0] SEL_S   = 3'd2;
  localparam logic [2:0] SEL_B   = 3'd3;
  localparam logic [2:0] SEL_U   = 3'd4;
  localparam logic [2:0] SEL_J   = 3'd5;
  localparam logic [2:0] SEL_4   = 3'd6;
  localparam logic [2:0] SEL_RSV = 3'd7;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_op1;
  logic [XLEN-1:0] r_ex_op2;
  logic [XLEN-1:0] r_ex_pc;
  logic            r_ex_jump;
  logic            r_ex_trap;
  logic            r_held_load;
  logic [4:0]      r_held_rd;
  logic [31:0]     r_bubble_count;

  logic signed [31:0] w_i32, w_s32, w_b32, w_u32, w_j32;
  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;
  logic               w_slot_free;
  logic               w_rs1_used;
  logic               w_rs2_used;
  logic               w_hazard;
  logic               w_ready;
  logic               w_capture;
  logic               w_bubble_inc;
  logic               w_unused_opcode;

  // Raw 32-bit immediates, sign-extended to XLEN by the signed casts below.
  assign w_i32 = {{20{id_inst[31]}}, id_inst[31:20]};
  assign w_s32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
  assign w_b32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25],
                  id_inst[11:8], 1'b0};
  assign w_u32 = {id_inst[31:12], 12'b0};
  assign w_j32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20],
                  id_inst[30:21], 1'b0};
  assign w_unused_opcode = ^id_inst[6:0];

  assign w_op1 = id_op1_sel ? id_pc : id_rs1_data;

  always_comb begin
    w_op2 = '0;
    case (id_op2_sel)
      SEL_RS2: w_op2 = id_rs2_data;
      SEL_I:   w_op2 = XLEN'(w_i32);
      SEL_S:   w_op2 = XLEN'(w_s32);
      SEL_B:   w_op2 = XLEN'(w_b32);
      SEL_U:   w_op2 = XLEN'(w_u32);
      SEL_J:   w_op2 = XLEN'(w_j32);
      SEL_4:   w_op2 = XLEN'(4);
      default: w_op2 = '0;
    endcase
  end

  assign w_slot_free = !r_ex_valid || ex_ready;
  assign w_rs1_used  = !id_op1_sel || (id_op2_sel == SEL_B);
  assign w_rs2_used  = (id_op2_sel == SEL_RS2) || (id_op2_sel == SEL_S) ||
                       (id_op2_sel == SEL_B);
  assign w_hazard    = r_ex_valid && r_held_load && (r_held_rd != 5'd0) &&
                       (((r_held_rd == id_inst[19:15]) && w_rs1_used) ||
                        ((r_held_rd == id_inst[24:20]) && w_rs2_used));

  assign w_ready      = w_slot_free && !w_hazard && !kill && !reset;
  assign w_capture    = id_valid && w_ready;
  assign w_bubble_inc = id_valid && w_hazard && w_slot_free && !kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_op1       <= '0;
      r_ex_op2       <= '0;
      r_ex_pc        <= '0;
      r_ex_jump      <= 1'b0;
      r_ex_trap      <= 1'b0;
      r_held_load    <= 1'b0;
      r_held_rd      <= 5'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_bubble_inc)
        r_bubble_count <= r_bubble_count + 32'd1;
      if (kill) begin
        r_ex_valid  <= 1'b0;
        r_held_load <= 1'b0;
      end else if (w_capture) begin
        r_ex_valid  <= 1'b1;
        r_ex_op1    <= w_op1;
        r_ex_op2    <= w_op2;
        r_ex_pc     <= id_pc;
        r_ex_jump   <= id_jump;
        r_ex_trap   <= id_invalid || (id_op2_sel == SEL_RSV);
        r_held_load <= id_load;
        r_held_rd   <= id_inst[11:7];
      end else if (w_slot_free) begin
        // Bubble: an empty slot carries no load, so the hazard lasts one cycle.
        r_ex_valid  <= 1'b0;
        r_held_load <= 1'b0;
      end
    end
  end

  assign id_ready     = w_ready;
  assign ex_valid     = r_ex_valid;
  assign ex_op1       = r_ex_op1;
  assign ex_op2       = r_ex_op2;
  assign ex_pc        = r_ex_pc;
  assign ex_jump      = r_ex_jump;
  assign ex_trap      = r_ex_trap;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a vector table for operand formation plus
// hand-written sequences for stall, load-use, kill and reset corner cases.
module tb_operand_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            id_op1_sel;
  logic [2:0]      id_op2_sel;
  logic            id_invalid;
  logic            id_jump;
  logic            id_load;
  logic            kill;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_pc;
  logic            ex_jump;
  logic            ex_trap;
  logic [31:0]     bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_invalid(id_invalid), .id_jump(id_jump), .id_load(id_load), .kill(kill),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_pc(ex_pc), .ex_jump(ex_jump), .ex_trap(ex_trap),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op1_sel;
    logic [2:0]  op2_sel;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        invalid;
    logic        jump;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic        e_trap;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic op1, input logic [2:0] op2, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic inv, input logic jmp, input logic ld);
    id_valid    = 1'b1;
    id_op1_sel  = op1;
    id_op2_sel  = op2;
    id_inst     = inst;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
    id_invalid  = inv;
    id_jump     = jmp;
    id_load     = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_op1"}, ex_op1, 32'd0);
    chk({tag, "_op2"}, ex_op2, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_jt"}, {30'd0, ex_jump, ex_trap}, 32'd0);
    chk({tag, "_bub"}, bubble_count, 32'd0);
    chk({tag, "_idrdy"}, {31'd0, id_ready}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd1, 32'hFFF10093, 32'h1000, 32'h10, 32'h0, 1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{1'b1, 3'd4, 32'h12345097, 32'h100, 32'h55, 32'h0, 1'b0, 1'b0, 32'h100, 32'h12345000, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 32'h00000033, 32'h1004, 32'h1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h1, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 32'hFE512E23, 32'h1008, 32'h20, 32'h5, 1'b0, 1'b0, 32'h20, 32'hFFFFFFFC, 1'b0};
    vecs[4]  = '{1'b0, 3'd3, 32'h00000463, 32'h100C, 32'h7, 32'h0, 1'b0, 1'b1, 32'h7, 32'h8, 1'b0};
    vecs[5]  = '{1'b1, 3'd3, 32'hFE001FE3, 32'h1010, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1010, 32'hFFFFFFFE, 1'b0};
    vecs[6]  = '{1'b1, 3'd5, 32'h001000EF, 32'h1014, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1014, 32'h800, 1'b0};
    vecs[7]  = '{1'b1, 3'd5, 32'h8000006F, 32'h1018, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1018, 32'hFFF00000, 1'b0};
    vecs[8]  = '{1'b1, 3'd6, 32'h0000006F, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h4, 1'b0};
    vecs[9]  = '{1'b0, 3'd7, 32'h00500093, 32'h1020, 32'h3, 32'h0, 1'b0, 1'b0, 32'h3, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'h1024, 32'h9, 32'h0, 1'b1, 1'b0, 32'h9, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 3'd1, 32'h7FF00093, 32'h1028, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h7FF, 1'b0};

    reset = 1'b1;
    kill = 1'b0;
    ex_ready = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    @(negedge clk);
    reset = 1'b0;

    // Operand formation table, execute always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op1_sel, vecs[i].op2_sel, vecs[i].inst, vecs[i].pc, vecs[i].rs1,
            vecs[i].rs2, vecs[i].invalid, vecs[i].jump, 1'b0);
      ex_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_idrdy", i), {31'd0, id_ready}, 32'd1);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_op1", i), ex_op1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), ex_op2, vecs[i].e_op2);
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("v%0d_jump", i), {31'd0, ex_jump}, {31'd0, vecs[i].jump});
      chk($sformatf("v%0d_trap", i), {31'd0, ex_trap}, {31'd0, vecs[i].e_trap});
    end
    @(negedge clk);
    id_valid = 1'b0;
    step();
    chk("idle_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("table_bubbles", bubble_count, 32'd0);

    // AUIPC held for three cycles while execute stalls.
    @(negedge clk);
    drive(1'b1, 3'd4, 32'h12345097, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("auipc_cap_op1", ex_op1, 32'h100);
    @(negedge clk);
    ex_ready = 1'b0;
    drive(1'b0, 3'd1, 32'hFFF10093, 32'h104, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_idrdy", c), {31'd0, id_ready}, 32'd0);
      step();
      chk($sformatf("stall%0d_valid", c), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("stall%0d_op1", c), ex_op1, 32'h100);
      chk($sformatf("stall%0d_op2", c), ex_op2, 32'h12345000);
      chk($sformatf("stall%0d_pc", c), ex_pc, 32'h100);
      @(negedge clk);
    end
    ex_ready = 1'b1;
    #1;
    chk("unstall_idrdy", {31'd0, id_ready}, 32'd1);
    step();
    chk("unstall_op1", ex_op1, 32'h10);
    chk("unstall_op2", ex_op2, 32'hFFFFFFFF);

    // LW x5 then ADD x6,x5,x7: one bubble.
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h00012283, 32'h300, 32'h400, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    chk("lw_op1", ex_op1, 32'h400);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'h00728333, 32'h304, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_idrdy", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_count", bubble_count, 32'd1);
    @(negedge clk);
    #1;
    chk("lu_idrdy_after", {31'd0, id_ready}, 32'd1);
    step();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_op1", ex_op1, 32'h11);
    chk("lu_add_op2", ex_op2, 32'h22);
    chk("lu_add_pc", ex_pc, 32'h304);
    chk("lu_count_once", bubble_count, 32'd1);

    // Load to x0 never stalls.
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h00012003, 32'h308, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    drive(1'b0, 3'd0, 32'h00700333, 32'h30C, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0_idrdy", {31'd0, id_ready}, 32'd1);
    step();

    // LW x5 then SW x5 (rs2 via S_IMM) stalls.
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h00012283, 32'h310, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    drive(1'b0, 3'd2, 32'hFE512E23, 32'h314, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("sw_idrdy", {31'd0, id_ready}, 32'd0);
    step();
    chk("sw_count", bubble_count, 32'd2);
    @(negedge clk);
    step();
    chk("sw_op2", ex_op2, 32'hFFFFFFFC);

    // Rs2 field matches but op2 is I_IMM with op1=PC: no stall.
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h00012283, 32'h318, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    drive(1'b1, 3'd1, 32'h00500093, 32'h31C, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("imm_nohaz_idrdy", {31'd0, id_ready}, 32'd1);
    step();
    chk("imm_nohaz_op2", ex_op2, 32'h5);

    // Kill with a held instruction and execute stalled.
    @(negedge clk);
    ex_ready = 1'b0;
    kill = 1'b1;
    drive(1'b0, 3'd1, 32'hFFF10093, 32'h320, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("kill_idrdy", {31'd0, id_ready}, 32'd0);
    step();
    chk("kill_valid", {31'd0, ex_valid}, 32'd0);
    chk("kill_count", bubble_count, 32'd2);
    @(negedge clk);
    kill = 1'b0;
    ex_ready = 1'b1;
    step();
    chk("post_kill_pc", ex_pc, 32'h320);

    // Kill dominates a load-use hazard: no bubble counted.
    @(negedge clk);
    drive(1'b0, 3'd1, 32'h00012283, 32'h324, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    kill = 1'b1;
    drive(1'b0, 3'd0, 32'h00728333, 32'h328, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("killhaz_valid", {31'd0, ex_valid}, 32'd0);
    chk("killhaz_count", bubble_count, 32'd2);
    @(negedge clk);
    kill = 1'b0;

    // Reset asserted mid-stall.
    drive(1'b1, 3'd4, 32'h12345097, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    @(negedge clk);
    ex_ready = 1'b0;
    drive(1'b0, 3'd1, 32'hFFF10093, 32'h404, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("prerst_valid", {31'd0, ex_valid}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    chk_all_zero("rsthold");
    @(negedge clk);
    reset = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk("postrst_idrdy", {31'd0, id_ready}, 32'd1);
    step();
    chk("postrst_valid", {31'd0, ex_valid}, 32'd1);
    chk("postrst_op1", ex_op1, 32'h10);
    chk("postrst_op2", ex_op2, 32'hFFFFFFFF);
    chk("postrst_pc", ex_pc, 32'h404);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid  input  1  decode holds an instruction.
REQ-005 SHALL have port id_ready  output  1  stage accepts the decode instruction this cycle.
REQ-006 SHALL have port id_pc  input  XLEN  instruction address.
REQ-007 SHALL have port id_inst  input  32  raw instruction word.
REQ-008 SHALL have port id_rs1_data  input  XLEN  register-file rs1 value.
REQ-009 SHALL have port id_rs2_data  input  XLEN  register-file rs2 value.
REQ-010 SHALL have port id_op1_sel  input  1  0=RS1, 1=PC.
REQ-011 SHALL have port id_op2_sel  input  3  0=RS2, 1=I_IMM, 2=S_IMM, 3=B_IMM, 4=U_IMM, 5=J_IMM, 6=FOUR, 7=reserved.
REQ-012 SHALL have port id_invalid  input  1  decode flagged an illegal instruction.
REQ-013 SHALL have port id_jump  input  1  jump/branch instruction.
REQ-014 SHALL have port id_load  input  1  load instruction.
REQ-015 SHALL have port kill  input  1  flush from a redirecting later stage.
REQ-016 SHALL have port ex_ready  input  1  execute accepts the held operands.
REQ-017 SHALL have port ex_valid  output  1  held operands are valid.
REQ-018 SHALL have ports ex_op1, ex_op2, ex_pc  output  XLEN each  registered operands and address.
REQ-019 SHALL have ports ex_jump, ex_trap  output  1 each  registered jump flag; illegal-instruction flag.
REQ-020 SHALL have port bubble_count  output  32  count of inserted load-use bubbles.

Function
REQ-021 SHALL compute immediates from id_inst per RV32I I/S/B/U/J formats, sign-extended to XLEN; FOUR yields 4.
REQ-022 SHALL select op1 = id_op1_sel ? id_pc : id_rs1_data, and op2 per id_op2_sel.
REQ-023 SHALL define slot_free = !ex_valid || ex_ready.
REQ-024 SHALL assert hazard when ex_valid && held_load && held_rd != 0 && (held_rd == id_inst[19:15] with rs1 used, or held_rd == id_inst[24:20] with op2_sel in {RS2,S_IMM,B_IMM}); rs1 is used when op1_sel=RS1 or op2_sel=B_IMM.
REQ-025 SHALL drive id_ready = slot_free && !hazard && !kill, combinationally.
REQ-026 SHALL capture operands, id_pc, id_jump, id_load, rd=id_inst[11:7] and set ex_valid=1 on the edge where id_valid && id_ready (1-cycle latency).
REQ-027 SHALL set ex_valid=0 (bubble) on the edge where slot_free and no capture occurs.
REQ-028 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready.
REQ-029 SHALL, when kill=1, clear ex_valid on the next edge regardless of ex_ready and accept nothing; kill dominates hazard and capture.
REQ-030 SHALL set ex_trap=1 on capture when id_invalid=1 or id_op2_sel=7; for op2_sel=7, ex_op2 is 0.
REQ-031 SHALL increment bubble_count by 1 on each edge where id_valid && hazard && slot_free && !kill, wrapping 0xFFFFFFFF -> 0.
REQ-032 SHALL register hazard at most one cycle per load: once the bubble occupies the slot, held_load=0 and hazard clears.

Reset
REQ-033 SHALL, on reset assertion, immediately force ex_valid=0, ex_op1=ex_op2=ex_pc=0, ex_jump=ex_trap=0, held_load=0, held_rd=0, bubble_count=0, including mid-stall.
REQ-034 SHALL hold id_ready=0 while reset is asserted and resume capture on the first edge after deassertion.

Verification
REQ-035 SHALL verify ADDI x1,x2,-1 (inst 0xFFF10093, rs1_data 0x10, op1=RS1, op2=I_IMM), ex_ready=1 -> next cycle ex_valid=1, ex_op1=0x10, ex_op2=0xFFFFFFFF.
REQ-036 SHALL verify AUIPC (inst 0x12345097, pc 0x100, op1=PC, op2=U_IMM) with ex_ready=0 for 3 cycles -> ex_op1=0x100, ex_op2=0x12345000 held; id_ready=0 throughout.
REQ-037 SHALL verify LW x5 followed by ADD x6,x5,x7 -> one cycle id_ready=0, ex_valid=0 bubble, bubble_count=1, ADD captured next cycle.
REQ-038 SHALL verify kill=1 with id_valid=1 and ex_valid=1 -> next cycle ex_valid=0, no capture, bubble_count unchanged.
REQ-039 SHALL verify op2_sel=7 or id_invalid=1 -> ex_trap=1, ex_op2=0; JAL with op2=FOUR -> ex_op2=4, ex_jump=1.
REQ-040 SHALL verify reset asserted mid-stall -> all outputs 0 within the same cycle; first instruction after release captured normally.
